// File: rtl/fft_frame_packer.sv
// Packs a continuous sample stream into FRAME_LEN-sample frames through a two-bank
// ping-pong buffer; samples arriving while both banks are full are dropped and counted.
module fft_frame_packer #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [CNT_W-1:0]  drop_cnt
);
    localparam int IDX_W = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Handshake: a sample leaves when out_valid & out_ready at a rising edge; while
    // out_valid is high and out_ready low, out_data/out_sop/out_eop do not change.
    typedef enum logic {W_WAIT = 1'b0, W_FILL = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_SEND = 1'b1} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [1:0]        full_q, full_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              wr_en;
    logic              set_full;
    logic              clr_full;
    logic              drop;
    logic [DATA_W-1:0] mem_q [0:2*FRAME_LEN-1];

    // Write side. wr_idx is always 0 in W_WAIT, so the first sample lands at index 0.
    always_comb begin
        w_state_d = w_state_q;
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        wr_en     = 1'b0;
        set_full  = 1'b0;
        drop      = 1'b0;
        case (w_state_q)
            W_WAIT: begin
                if (!full_q[wr_bank_q]) begin
                    w_state_d = W_FILL;
                    if (in_valid) begin
                        wr_en    = 1'b1;
                        wr_idx_d = IDX_W'(1);
                    end
                end else if (in_valid) begin
                    drop = 1'b1;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        set_full  = 1'b1;
                        wr_bank_d = ~wr_bank_q;
                        wr_idx_d  = '0;
                        w_state_d = W_WAIT;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end
            default: w_state_d = W_WAIT;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        clr_full  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    r_state_d = R_SEND;
                    rd_idx_d  = '0;
                end
            end
            R_SEND: begin
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_idx_d  = '0;
                        r_state_d = R_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Set and clear never target the same bank: the bank being filled is never full.
    always_comb begin
        full_d = full_q;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q  <= W_WAIT;
            r_state_q  <= R_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            full_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            full_q     <= full_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{wr_bank_q, wr_idx_q}] <= in_data;
    end

    assign out_valid = (r_state_q == R_SEND);
    assign out_data  = out_valid ? mem_q[{rd_bank_q, rd_idx_q}] : '0;
    assign out_sop   = out_valid && (rd_idx_q == '0);
    assign out_eop   = out_valid && (rd_idx_q == LAST_IDX);
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed bench for fft_frame_packer: streaming, backpressure, drops, gaps, reset,
// and counter saturation on a second instance with a 4-bit drop counter.
module tb_fft_frame_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic [11:0] out_data, out_data6;
    logic        out_valid, out_sop, out_eop;
    logic        out_valid6, out_sop6, out_eop6;
    logic [15:0] drop_cnt;
    logic [3:0]  drop_cnt6;

    int n_cmp = 0;
    int n_fail = 0;
    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    fft_frame_packer #(.DATA_W(12), .FRAME_LEN(64), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .drop_cnt(drop_cnt)
    );

    fft_frame_packer #(.DATA_W(12), .FRAME_LEN(64), .CNT_W(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data6), .out_valid(out_valid6), .out_ready(out_ready),
        .out_sop(out_sop6), .out_eop(out_eop6), .drop_cnt(drop_cnt6)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back({out_sop, out_eop, out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 12'h5A5; out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic push_frame(input int base);
        for (int i = 0; i < 64; i++) exp_q.push_back({(i == 0), (i == 63), 12'(base + i)});
    endtask

    task automatic wait_items(input int n);
        int t = 0;
        while (got_q.size() < n && t < 3000) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 12'h123; out_ready = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({out_valid, out_sop, out_eop, out_data, drop_cnt} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b sop=%b eop=%b data=%h drop=%0d, required all 0",
                     out_valid, out_sop, out_eop, out_data, drop_cnt);
        end
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %b, required 0", out_valid);
        end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 128; n++) begin
            in_valid = 1'b1; in_data = 12'(n);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stream_drop: got %0d, required 0", drop_cnt);
        end
        push_frame(0); push_frame(64);
        wait_items(128);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stream[%0d]: got sop/eop/data %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 200; n++) begin
            in_valid = 1'b1; in_data = 12'(n);
            tick();
        end
        n_cmp++;
        if (drop_cnt !== 16'd72) begin
            n_fail++;
            $display("FAIL bp_drop: got %0d, required 72", drop_cnt);
        end
        out_ready = 1'b1;
        for (int n = 200; n < 400; n++) begin
            in_data = 12'(n);
            tick();
        end
        in_valid = 1'b0;
        // Bank 0 frees on the eop handshake of sample 63, which happens with sample 263.
        push_frame(0); push_frame(64); push_frame(264);
        wait_items(192);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_stream[%0d]: got sop/eop/data %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_toggle_ready();
        logic        prev_stall = 1'b0;
        logic [14:0] prev_out = '0;
        int          k = 0;
        do_reset();
        push_frame(0); push_frame(64);
        while (k < 1000 && !(k >= 128 && got_q.size() >= 128)) begin
            in_valid  = (k < 128);
            in_data   = 12'(k);
            out_ready = k[0];
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if ({out_valid, out_sop, out_eop, out_data} !== prev_out) begin
                    n_fail++;
                    $display("FAIL toggle_stable@%0d: got v/sop/eop/data %h, required %h",
                             k, {out_valid, out_sop, out_eop, out_data}, prev_out);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_sop, out_eop, out_data};
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL toggle_stream[%0d]: got sop/eop/data %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        logic [11:0] v;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            v = (i == 0) ? 12'h800 : (i == 1) ? 12'h7FF : 12'(i * 293);
            exp_q.push_back({(i % 64 == 0), (i % 64 == 63), v});
            in_valid = 1'b1; in_data = v;
            tick();
            in_valid = 1'b0; in_data = 12'hABC;
            repeat (3) tick();
        end
        wait_items(128);
        n_cmp++;
        if (drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL gaps_drop: got %0d, required 0", drop_cnt);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gaps_stream[%0d]: got sop/eop/data %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 150; n++) begin
            in_valid = 1'b1; in_data = 12'(100 + n);
            tick();
        end
        n_cmp++;
        if ({out_valid, out_sop, out_data, drop_cnt} !== {1'b1, 1'b1, 12'd100, 16'd22}) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b sop=%b data=%0d drop=%0d, required 1 1 100 22",
                     out_valid, out_sop, out_data, drop_cnt);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, out_sop, out_eop, out_data, drop_cnt} !== 31'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b sop=%b eop=%b data=%h drop=%0d, required all 0",
                     out_valid, out_sop, out_eop, out_data, drop_cnt);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            in_data = 12'(500 + n);
            tick();
        end
        in_valid = 1'b0;
        push_frame(500);
        wait_items(64);
        for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got sop/eop/data %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int n = 0; n < 142; n++) begin
            in_data = 12'(n);
            tick();
        end
        n_cmp++;
        if ({drop_cnt6, drop_cnt} !== {4'd14, 16'd14}) begin
            n_fail++;
            $display("FAIL sat_14: got cnt4=%0d cnt16=%0d, required 14 14", drop_cnt6, drop_cnt);
        end
        tick();
        n_cmp++;
        if ({drop_cnt6, drop_cnt} !== {4'd15, 16'd15}) begin
            n_fail++;
            $display("FAIL sat_15: got cnt4=%0d cnt16=%0d, required 15 15", drop_cnt6, drop_cnt);
        end
        repeat (57) tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({drop_cnt6, drop_cnt} !== {4'd15, 16'd72}) begin
            n_fail++;
            $display("FAIL sat_hold: got cnt4=%0d cnt16=%0d, required 15 72", drop_cnt6, drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle_ready();
        test_gaps();
        test_mid_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
